valu_seq_exec: RTL and testbench

//  Sequential vector execute stage downstream of the vector ALU control decoder.

---
 rtl/valu_seq_exec.sv | 117 +++++++++++
 tb/tb_valu_seq_exec.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_seq_exec.sv
// Vector execute stage: add/sub/scalar-mul/dot over VLEN elements, one element per cycle.
// Latency VLEN+1 cycles to done_o; no backpressure, start_i is ignored unless idle (caller retries).
module valu_seq_exec #(
    parameter int VLEN = 4,
    parameter int ELEN = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [2:0]           ctrl_i,
    input  logic [VLEN*ELEN-1:0] vs1_i,
    input  logic [VLEN*ELEN-1:0] vs2_i,
    input  logic [ELEN-1:0]      rs1_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 illegal_o,
    output logic [VLEN*ELEN-1:0] result_o
);

    localparam int IDXW = $clog2(VLEN) + 1;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_DOT = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_ctrl;
    logic [VLEN*ELEN-1:0]  r_vs1;
    logic [VLEN*ELEN-1:0]  r_vs2;
    logic [ELEN-1:0]       r_rs1;
    logic [ELEN-1:0]       r_acc;
    logic [IDXW-1:0]       r_idx;
    logic [VLEN*ELEN-1:0]  r_res;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_legal;
    logic [IDXW-2:0]       w_el;
    logic [ELEN-1:0]       w_a;
    logic [ELEN-1:0]       w_b;
    logic [ELEN-1:0]       w_prod;
    logic [ELEN-1:0]       w_acc_nxt;

    assign w_accept  = (r_state == S_IDLE) && start_i;
    assign w_last    = (r_idx == IDXW'(VLEN - 1));
    assign w_el      = r_idx[IDXW-2:0];
    assign w_a       = r_vs1[w_el*ELEN +: ELEN];
    assign w_b       = r_vs2[w_el*ELEN +: ELEN];
    assign w_prod    = w_a * w_b;
    assign w_acc_nxt = r_acc + w_prod;
    assign w_legal   = (r_ctrl == OP_ADD) || (r_ctrl == OP_SUB) ||
                       (r_ctrl == OP_MUL) || (r_ctrl == OP_DOT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_EXEC;
            S_EXEC:  if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (r_state == S_EXEC);
        done_o    = (r_state == S_DONE);
        illegal_o = (r_state == S_DONE) && !w_legal;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ctrl <= 3'b000;
            r_vs1  <= '0;
            r_vs2  <= '0;
            r_rs1  <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_res  <= '0;
        end else if (w_accept) begin
            r_ctrl <= ctrl_i;
            r_vs1  <= vs1_i;
            r_vs2  <= vs2_i;
            r_rs1  <= rs1_i;
            r_acc  <= '0;
            r_idx  <= '0;
            r_res  <= '0;
        end else if (r_state == S_EXEC) begin
            // idx stops at VLEN on the last element, which fits IDXW bits without wrapping
            r_idx <= r_idx + 1'b1;
            case (r_ctrl)
                OP_ADD: r_res[w_el*ELEN +: ELEN] <= w_a + w_b;
                OP_SUB: r_res[w_el*ELEN +: ELEN] <= w_b - w_a;
                OP_MUL: r_res[w_el*ELEN +: ELEN] <= w_b * r_rs1;
                OP_DOT: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) r_res[ELEN-1:0] <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_res;

endmodule

// File: tb/tb_valu_seq_exec.sv
module tb_valu_seq_exec;

    localparam int VLEN = 4;
    localparam int ELEN = 32;
    localparam int W    = VLEN * ELEN;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [2:0]    ctrl_i = 3'b000;
    logic [W-1:0]  vs1_i = '0;
    logic [W-1:0]  vs2_i = '0;
    logic [ELEN-1:0] rs1_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          illegal_o;
    logic [W-1:0]  result_o;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    valu_seq_exec #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ctrl_i    (ctrl_i),
        .vs1_i     (vs1_i),
        .vs2_i     (vs2_i),
        .rs1_i     (rs1_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .illegal_o (illegal_o),
        .result_o  (result_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [ELEN-1:0] s);
        exp_t e;
        logic [ELEN-1:0] acc, x, y, t;
        e.res = '0;
        e.ill = 1'b0;
        acc   = '0;
        for (int i = 0; i < VLEN; i++) begin
            x = a[i*ELEN +: ELEN];
            y = b[i*ELEN +: ELEN];
            case (c)
                3'b010: e.res[i*ELEN +: ELEN] = x + y;
                3'b110: e.res[i*ELEN +: ELEN] = y - x;
                3'b000: begin t = y * s; e.res[i*ELEN +: ELEN] = t; end
                3'b001: begin t = x * y; acc = acc + t; end
                default: e.ill = 1'b1;
            endcase
        end
        if (c == 3'b001) e.res[ELEN-1:0] = acc;
        return e;
    endfunction

    // Drives one op from idle, scrambles inputs after accept, waits for done_o.
    task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [ELEN-1:0] s, output int lat, output logic [W-1:0] res,
                          output logic ill, output bit seen);
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = c;
        vs1_i   = a;
        vs2_i   = b;
        rs1_i   = s;
        sb_q.push_back(model(c, a, b, s));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        ctrl_i  = 3'b111;
        vs1_i   = {$urandom, $urandom, $urandom, $urandom};
        vs2_i   = {$urandom, $urandom, $urandom, $urandom};
        rs1_i   = $urandom;
        seen = 1'b0;
        lat  = 0;
        res  = '0;
        ill  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_i);
            lat++;
            if (done_o) begin
                seen = 1'b1;
                res  = result_o;
                ill  = illegal_o;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({busy_o, done_o, illegal_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000", {busy_o, done_o, illegal_o});
        end
        n_cmp++;
        if (result_o !== '0) begin
            n_err++;
            $display("FAIL reset_result got %h want 0", result_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic check_op(input string name, input logic [2:0] c, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [ELEN-1:0] s);
        int lat; logic [W-1:0] res; logic ill; bit seen; exp_t e;
        run_op(c, a, b, s, lat, res, ill, seen);
        e = sb_q.pop_front();
        n_cmp++;
        if (!seen || lat !== 5) begin
            n_err++;
            $display("FAIL %s_latency got %0d (seen=%0b) want 5", name, lat, seen);
        end
        n_cmp++;
        if (res !== e.res) begin
            n_err++;
            $display("FAIL %s_result got %h want %h", name, res, e.res);
        end
        n_cmp++;
        if (ill !== e.ill) begin
            n_err++;
            $display("FAIL %s_illegal got %b want %b", name, ill, e.ill);
        end
    endtask

    task automatic test_add();
        check_op("add", 3'b010, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, 32'd0);
        n_cmp++;
        if (result_o !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            n_err++;
            $display("FAIL add_const got %h want 44/33/22/11", result_o);
        end
    endtask

    task automatic test_sub();
        check_op("sub", 3'b110, {32'd0, 32'd0, 32'd0, 32'd1}, '0, 32'd0);
        n_cmp++;
        if (result_o !== {96'd0, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL sub_wrap got %h want elem0 ffffffff", result_o);
        end
    endtask

    task automatic test_mul();
        check_op("mul", 3'b000, {$urandom, $urandom, $urandom, $urandom},
                 {32'd1, 32'd2, 32'd3, 32'h8000_0000}, 32'd2);
        n_cmp++;
        if (result_o !== {32'd2, 32'd4, 32'd6, 32'd0}) begin
            n_err++;
            $display("FAIL mul_const got %h want 2/4/6/0", result_o);
        end
    endtask

    task automatic test_dot();
        check_op("dot", 3'b001, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8}, 32'd9);
        n_cmp++;
        if (result_o !== {96'd0, 32'd70}) begin
            n_err++;
            $display("FAIL dot_const got %h want elem0=70", result_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_err++;
            $display("FAIL dot_single_pulse got done_o=%b want 0", done_o);
        end
        n_cmp++;
        if (result_o !== {96'd0, 32'd70}) begin
            n_err++;
            $display("FAIL dot_hold got %h want elem0=70", result_o);
        end
        check_op("dot_wrap", 3'b001, {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 32'd0);
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, n_done = 0, c_acc0 = -1, c_acc1 = -1;
        logic [W-1:0] a, b;
        exp_t e;
        a = {32'd7, 32'd6, 32'd5, 32'd4};
        b = {32'd70, 32'd60, 32'd50, 32'd40};
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk_i);
            start_i = (cyc < 12);
            ctrl_i  = (cyc == 0) ? 3'b010 : 3'b011;
            vs1_i   = a;
            vs2_i   = b;
            if (start_i && !busy_o && !done_o) begin
                n_acc++;
                if (n_acc == 1) c_acc0 = cyc; else c_acc1 = cyc;
                sb_q.push_back(model(ctrl_i, a, b, rs1_i));
            end
            if (done_o) begin
                n_done++;
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_unexpected_done at cycle %0d want none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (result_o !== e.res || illegal_o !== e.ill) begin
                        n_err++;
                        $display("FAIL b2b_result got %h/%b want %h/%b", result_o, illegal_o, e.res, e.ill);
                    end
                end
            end
        end
        start_i = 1'b0;
        n_cmp++;
        if (n_acc !== 2 || n_done !== 2) begin
            n_err++;
            $display("FAIL b2b_count got accepts=%0d dones=%0d want 2/2", n_acc, n_done);
        end
        n_cmp++;
        if (c_acc1 - c_acc0 !== 6) begin
            n_err++;
            $display("FAIL b2b_spacing got %0d want 6", c_acc1 - c_acc0);
        end
        sb_q.delete();
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        ctrl_i  = 3'b010;
        vs1_i   = {32'd1, 32'd1, 32'd1, 32'd1};
        vs2_i   = {32'd2, 32'd2, 32'd2, 32'd2};
        @(posedge clk_i);
        #1 start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b1 || result_o === '0) begin
            n_err++;
            $display("FAIL rstmid_pre got busy=%b res=%h want busy=1 partial", busy_o, result_o);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || result_o !== '0) begin
            n_err++;
            $display("FAIL rstmid_clear got busy=%b res=%h want 0/0", busy_o, result_o);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            if (k == 1) rst_i = 1'b1;
            if (done_o) n_done++;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL rstmid_no_done got %0d pulses want 0", n_done);
        end
        check_op("rstmid_add", 3'b010, {32'd100, 32'd200, 32'd300, 32'd400},
                 {32'd1, 32'd2, 32'd3, 32'd4}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_dot();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
